rename_nway: RTL and testbench

// - Parametrised N-wide register-rename stage; successor to the fixed 2-wide combinational rename.
// - Sits between the decode pipereg and dispatch.
// - Per group: reads spec_rat for all sources and old destinations, pops free pregs in order,

---
 rtl/rename_pkg.sv | 31 +++
 rtl/rename_dep_matrix.sv | 51 +++++
 rtl/rename_nway.sv | 176 +++++++++++++++++
 tb/tb_rename_nway.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// Shared types and slot-counting helpers for the N-wide rename stage.
// Counting helpers operate on a mask zero-extended to the widest supported group.
package rename_pkg;

  localparam int LREG_W_DEF = 5;
  localparam int PREG_W_DEF = 6;
  localparam int MAX_WIDTH  = 8;

  typedef logic [LREG_W_DEF-1:0] lreg_t;
  typedef logic [PREG_W_DEF-1:0] preg_t;
  typedef logic [MAX_WIDTH-1:0]  slot_mask_t;
  typedef logic [3:0]            slot_cnt_t;

  function automatic slot_cnt_t popcount(input slot_mask_t v);
    slot_cnt_t c;
    c = '0;
    for (int k = 0; k < MAX_WIDTH; k++) c = c + slot_cnt_t'(v[k]);
    return c;
  endfunction

  // Number of set bits strictly below position upto.
  function automatic slot_cnt_t prefix_popcount(input slot_mask_t v, input int upto);
    slot_cnt_t c;
    c = '0;
    for (int k = 0; k < MAX_WIDTH; k++) begin
      if (k < upto) c = c + slot_cnt_t'(v[k]);
    end
    return c;
  endfunction

endpackage

// File: rtl/rename_dep_matrix.sv
// Intra-group dependency resolution for any group width: source bypass selects,
// old-destination selects and the youngest-writer mask used for RAT writes.
module rename_dep_matrix #(
  parameter int WIDTH  = 4,
  parameter int LREG_W = 5,
  parameter int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]              wr,
  input  logic [WIDTH-1:0][LREG_W-1:0]  lrd,
  input  logic [WIDTH-1:0][LREG_W-1:0]  lrs1,
  input  logic [WIDTH-1:0][LREG_W-1:0]  lrs2,
  output logic [WIDTH-1:0]              raw1_hit,
  output logic [WIDTH-1:0]              raw2_hit,
  output logic [WIDTH-1:0]              old_hit,
  output logic [WIDTH-1:0][IDX_W-1:0]   raw1_sel,
  output logic [WIDTH-1:0][IDX_W-1:0]   raw2_sel,
  output logic [WIDTH-1:0][IDX_W-1:0]   old_sel,
  output logic [WIDTH-1:0]              youngest
);

  // Ascending scan over older slots: the last match wins, i.e. the youngest older writer.
  always_comb begin
    raw1_hit = '0;
    raw2_hit = '0;
    old_hit  = '0;
    raw1_sel = '0;
    raw2_sel = '0;
    old_sel  = '0;
    youngest = wr;
    for (int j = 0; j < WIDTH; j++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i < j && wr[i]) begin
          if (lrd[i] == lrs1[j]) begin
            raw1_hit[j] = 1'b1;
            raw1_sel[j] = IDX_W'(i);
          end
          if (lrd[i] == lrs2[j]) begin
            raw2_hit[j] = 1'b1;
            raw2_sel[j] = IDX_W'(i);
          end
          if (lrd[i] == lrd[j]) begin
            old_hit[j] = 1'b1;
            old_sel[j] = IDX_W'(i);
          end
        end
        if (i > j && wr[i] && lrd[i] == lrd[j]) youngest[j] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rename_nway.sv
// N-wide register rename stage between decode and dispatch: allocates pregs,
// resolves intra-group hazards, updates spec_rat and registers the renamed group.
module rename_nway
  import rename_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int LREG_W    = LREG_W_DEF,
  parameter int PREG_W    = PREG_W_DEF,
  parameter int PAYLOAD_W = 160,
  parameter int CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          flush_valid,
  input  logic [WIDTH-1:0]              in_valid,
  output logic                          in_ready,
  input  logic [WIDTH*LREG_W-1:0]       in_lrs1,
  input  logic [WIDTH*LREG_W-1:0]       in_lrs2,
  input  logic [WIDTH*LREG_W-1:0]       in_lrd,
  input  logic [WIDTH-1:0]              in_src1_is_reg,
  input  logic [WIDTH-1:0]              in_src2_is_reg,
  input  logic [WIDTH-1:0]              in_need_to_wb,
  input  logic [WIDTH*PAYLOAD_W-1:0]    in_payload,
  output logic [3*WIDTH*LREG_W-1:0]     rat_rd_addr,
  input  logic [3*WIDTH*PREG_W-1:0]     rat_rd_data,
  output logic [WIDTH-1:0]              rat_wr_en,
  output logic [WIDTH*LREG_W-1:0]       rat_wr_addr,
  output logic [WIDTH*PREG_W-1:0]       rat_wr_data,
  input  logic [CNT_W-1:0]              fl_avail_cnt,
  input  logic [WIDTH*PREG_W-1:0]       fl_prd,
  output logic [CNT_W-1:0]              fl_alloc_cnt,
  output logic [WIDTH-1:0]              out_valid,
  input  logic                          out_ready,
  output logic [WIDTH*PREG_W-1:0]       out_prs1,
  output logic [WIDTH*PREG_W-1:0]       out_prs2,
  output logic [WIDTH*PREG_W-1:0]       out_prd,
  output logic [WIDTH*PREG_W-1:0]       out_old_prd,
  output logic [WIDTH*LREG_W-1:0]       out_lrd,
  output logic [WIDTH-1:0]              out_src1_is_reg,
  output logic [WIDTH-1:0]              out_src2_is_reg,
  output logic [WIDTH-1:0]              out_need_to_wb,
  output logic [WIDTH-1:0]              out_raw1,
  output logic [WIDTH-1:0]              out_raw2,
  output logic [WIDTH*PAYLOAD_W-1:0]    out_payload
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0][LREG_W-1:0] lrs1_a, lrs2_a, lrd_a;
  logic [WIDTH-1:0][PREG_W-1:0] rd1_a, rd2_a, rdd_a, fl_a;
  logic [WIDTH-1:0][PREG_W-1:0] prd_a, prs1_a, prs2_a, old_a;
  logic [WIDTH-1:0]             wr, raw1_hit, raw2_hit, old_hit, youngest;
  logic [WIDTH-1:0][IDX_W-1:0]  raw1_sel, raw2_sel, old_sel;
  slot_mask_t                   wr_mask;
  logic [CNT_W-1:0]             need;
  logic                         slot_ok, fire;

  assign lrs1_a = in_lrs1;
  assign lrs2_a = in_lrs2;
  assign lrd_a  = in_lrd;
  assign fl_a   = fl_prd;

  always_comb begin
    rat_rd_addr = '0;
    rd1_a       = '0;
    rd2_a       = '0;
    rdd_a       = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rat_rd_addr[3*LREG_W*i +: 3*LREG_W] = {lrd_a[i], lrs2_a[i], lrs1_a[i]};
      rd1_a[i] = rat_rd_data[3*PREG_W*i +: PREG_W];
      rd2_a[i] = rat_rd_data[3*PREG_W*i + PREG_W +: PREG_W];
      rdd_a[i] = rat_rd_data[3*PREG_W*i + 2*PREG_W +: PREG_W];
    end
  end

  // x0 and invalid slots never write, so they never allocate or bypass.
  always_comb begin
    wr      = '0;
    wr_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      wr[i]      = in_valid[i] & in_need_to_wb[i] & (lrd_a[i] != '0);
      wr_mask[i] = wr[i];
    end
  end

  assign need = CNT_W'(popcount(wr_mask));

  // Each writer takes the freelist entry at its rank among the group's writers.
  always_comb begin
    prd_a = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (wr[i]) begin
        for (int m = 0; m < WIDTH; m++) begin
          if (prefix_popcount(wr_mask, i) == slot_cnt_t'(m)) prd_a[i] = fl_a[m];
        end
      end
    end
  end

  rename_dep_matrix #(
    .WIDTH  (WIDTH),
    .LREG_W (LREG_W),
    .IDX_W  (IDX_W)
  ) u_dep (
    .wr       (wr),
    .lrd      (lrd_a),
    .lrs1     (lrs1_a),
    .lrs2     (lrs2_a),
    .raw1_hit (raw1_hit),
    .raw2_hit (raw2_hit),
    .old_hit  (old_hit),
    .raw1_sel (raw1_sel),
    .raw2_sel (raw2_sel),
    .old_sel  (old_sel),
    .youngest (youngest)
  );

  always_comb begin
    prs1_a = rd1_a;
    prs2_a = rd2_a;
    old_a  = rdd_a;
    for (int j = 0; j < WIDTH; j++) begin
      for (int m = 0; m < WIDTH; m++) begin
        if (raw1_hit[j] && raw1_sel[j] == IDX_W'(m)) prs1_a[j] = prd_a[m];
        if (raw2_hit[j] && raw2_sel[j] == IDX_W'(m)) prs2_a[j] = prd_a[m];
        if (old_hit[j]  && old_sel[j]  == IDX_W'(m)) old_a[j]  = prd_a[m];
      end
      if (lrs1_a[j] == '0) prs1_a[j] = '0;
      if (lrs2_a[j] == '0) prs2_a[j] = '0;
    end
  end

  assign slot_ok      = ~|out_valid | out_ready;
  assign in_ready     = slot_ok & (fl_avail_cnt >= need) & ~flush_valid;
  assign fire         = in_ready & in_valid[0];
  assign fl_alloc_cnt = fire ? need : '0;
  assign rat_wr_en    = {WIDTH{fire}} & youngest;
  assign rat_wr_addr  = in_lrd;
  assign rat_wr_data  = prd_a;

  // Output pipeline register: holds on stall, dropped by flush or reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid       <= '0;
      out_prs1        <= '0;
      out_prs2        <= '0;
      out_prd         <= '0;
      out_old_prd     <= '0;
      out_lrd         <= '0;
      out_src1_is_reg <= '0;
      out_src2_is_reg <= '0;
      out_need_to_wb  <= '0;
      out_raw1        <= '0;
      out_raw2        <= '0;
      out_payload     <= '0;
    end else begin
      if (flush_valid)    out_valid <= '0;
      else if (fire)      out_valid <= in_valid;
      else if (out_ready) out_valid <= '0;
      if (fire) begin
        out_prs1        <= prs1_a;
        out_prs2        <= prs2_a;
        out_prd         <= prd_a;
        out_old_prd     <= old_a;
        out_lrd         <= in_lrd;
        out_src1_is_reg <= in_src1_is_reg;
        out_src2_is_reg <= in_src2_is_reg;
        out_need_to_wb  <= in_need_to_wb;
        out_raw1        <= raw1_hit;
        out_raw2        <= raw2_hit;
        out_payload     <= in_payload;
      end
    end
  end

endmodule

// File: tb/tb_rename_nway.sv
// Randomized and directed bench for rename_nway against a sequential
// slot-by-slot rename model with its own RAT and output-register model.
module tb_rename_nway;

  localparam int W   = 4;
  localparam int LW  = 5;
  localparam int PW  = 6;
  localparam int PLW = 160;
  localparam int CW  = 3;

  logic                clock = 1'b0;
  logic                reset_n;
  logic                flush_valid;
  logic [W-1:0]        in_valid;
  logic                in_ready;
  logic [W*LW-1:0]     in_lrs1, in_lrs2, in_lrd;
  logic [W-1:0]        in_src1_is_reg, in_src2_is_reg, in_need_to_wb;
  logic [W*PLW-1:0]    in_payload;
  logic [3*W*LW-1:0]   rat_rd_addr;
  logic [3*W*PW-1:0]   rat_rd_data;
  logic [W-1:0]        rat_wr_en;
  logic [W*LW-1:0]     rat_wr_addr;
  logic [W*PW-1:0]     rat_wr_data;
  logic [CW-1:0]       fl_avail_cnt;
  logic [W*PW-1:0]     fl_prd;
  logic [CW-1:0]       fl_alloc_cnt;
  logic [W-1:0]        out_valid;
  logic                out_ready;
  logic [W*PW-1:0]     out_prs1, out_prs2, out_prd, out_old_prd;
  logic [W*LW-1:0]     out_lrd;
  logic [W-1:0]        out_src1_is_reg, out_src2_is_reg, out_need_to_wb;
  logic [W-1:0]        out_raw1, out_raw2;
  logic [W*PLW-1:0]    out_payload;

  rename_nway #(
    .WIDTH(W), .LREG_W(LW), .PREG_W(PW), .PAYLOAD_W(PLW), .CNT_W(CW)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .flush_valid     (flush_valid),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_lrs1         (in_lrs1),
    .in_lrs2         (in_lrs2),
    .in_lrd          (in_lrd),
    .in_src1_is_reg  (in_src1_is_reg),
    .in_src2_is_reg  (in_src2_is_reg),
    .in_need_to_wb   (in_need_to_wb),
    .in_payload      (in_payload),
    .rat_rd_addr     (rat_rd_addr),
    .rat_rd_data     (rat_rd_data),
    .rat_wr_en       (rat_wr_en),
    .rat_wr_addr     (rat_wr_addr),
    .rat_wr_data     (rat_wr_data),
    .fl_avail_cnt    (fl_avail_cnt),
    .fl_prd          (fl_prd),
    .fl_alloc_cnt    (fl_alloc_cnt),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_prs1        (out_prs1),
    .out_prs2        (out_prs2),
    .out_prd         (out_prd),
    .out_old_prd     (out_old_prd),
    .out_lrd         (out_lrd),
    .out_src1_is_reg (out_src1_is_reg),
    .out_src2_is_reg (out_src2_is_reg),
    .out_need_to_wb  (out_need_to_wb),
    .out_raw1        (out_raw1),
    .out_raw2        (out_raw2),
    .out_payload     (out_payload)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset_n) assert ((in_valid & 4'(in_valid + 4'd1)) == 4'd0)
      else $error("protocol: in_valid not contiguous from slot 0");
  end

  // stimulus for the current group
  logic [W-1:0]   s_valid, s_s1r, s_s2r, s_wb;
  logic [LW-1:0]  s_lrs1[W], s_lrs2[W], s_lrd[W];
  logic [PW-1:0]  s_fl[W];
  logic [PLW-1:0] s_pay[W];
  logic [CW-1:0]  s_cnt;
  logic [PW-1:0]  rat[32];

  // combinational expectations
  logic [PW-1:0]  e_prs1[W], e_prs2[W], e_prd[W], e_old[W];
  logic [W-1:0]   e_raw1, e_raw2, e_wen;
  int             e_need;

  // registered-output model
  logic [W-1:0]   m_valid, m_raw1, m_raw2, m_s1r, m_s2r, m_wb;
  logic [PW-1:0]  m_prs1[W], m_prs2[W], m_prd[W], m_old[W];
  logic [LW-1:0]  m_lrd[W];
  logic [PLW-1:0] m_pay[W];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = '0; m_raw1 = '0; m_raw2 = '0; m_s1r = '0; m_s2r = '0; m_wb = '0;
    for (int i = 0; i < W; i++) begin
      m_prs1[i] = '0; m_prs2[i] = '0; m_prd[i] = '0; m_old[i] = '0;
      m_lrd[i] = '0; m_pay[i] = '0;
    end
  endtask

  task automatic clear_stim();
    s_valid = '0; s_s1r = '0; s_s2r = '0; s_wb = '0; s_cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      s_lrs1[i] = '0; s_lrs2[i] = '0; s_lrd[i] = '0;
      s_fl[i]   = PW'(10 + i);
      s_pay[i]  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    end
  endtask

  task automatic drive_ports();
    in_valid = s_valid; in_src1_is_reg = s_s1r; in_src2_is_reg = s_s2r;
    in_need_to_wb = s_wb; fl_avail_cnt = s_cnt;
    for (int i = 0; i < W; i++) begin
      in_lrs1[i*LW +: LW]     = s_lrs1[i];
      in_lrs2[i*LW +: LW]     = s_lrs2[i];
      in_lrd[i*LW +: LW]      = s_lrd[i];
      in_payload[i*PLW +: PLW] = s_pay[i];
      fl_prd[i*PW +: PW]      = s_fl[i];
      rat_rd_data[3*PW*i +: 3*PW] = {rat[s_lrd[i]], rat[s_lrs2[i]], rat[s_lrs1[i]]};
    end
  endtask

  // Rename the group one slot at a time against a private copy of the map.
  task automatic compute_model();
    logic [PW-1:0] map[32];
    bit            written[32];
    int            last[32];
    int            k;
    map = rat;
    for (int r = 0; r < 32; r++) begin written[r] = 0; last[r] = -1; end
    k = 0;
    for (int j = 0; j < W; j++) begin
      e_prs1[j] = (s_lrs1[j] == 0) ? '0 : map[s_lrs1[j]];
      e_prs2[j] = (s_lrs2[j] == 0) ? '0 : map[s_lrs2[j]];
      e_raw1[j] = (s_lrs1[j] != 0) && written[s_lrs1[j]];
      e_raw2[j] = (s_lrs2[j] != 0) && written[s_lrs2[j]];
      e_old[j]  = map[s_lrd[j]];
      if (s_valid[j] && s_wb[j] && s_lrd[j] != 0) begin
        e_prd[j] = s_fl[k];
        k++;
        map[s_lrd[j]] = e_prd[j];
        written[s_lrd[j]] = 1;
        last[s_lrd[j]] = j;
      end else begin
        e_prd[j] = '0;
      end
    end
    e_need = k;
    for (int j = 0; j < W; j++)
      e_wen[j] = s_valid[j] && s_wb[j] && s_lrd[j] != 0 && last[s_lrd[j]] == j;
  endtask

  task automatic check_outputs();
    chk("out_valid", out_valid, m_valid);
    chk("out_raw1", out_raw1, m_raw1);
    chk("out_raw2", out_raw2, m_raw2);
    chk("out_src1_is_reg", out_src1_is_reg, m_s1r);
    chk("out_src2_is_reg", out_src2_is_reg, m_s2r);
    chk("out_need_to_wb", out_need_to_wb, m_wb);
    for (int i = 0; i < W; i++) begin
      chk($sformatf("out_prs1[%0d]", i), out_prs1[i*PW +: PW], m_prs1[i]);
      chk($sformatf("out_prs2[%0d]", i), out_prs2[i*PW +: PW], m_prs2[i]);
      chk($sformatf("out_prd[%0d]", i), out_prd[i*PW +: PW], m_prd[i]);
      chk($sformatf("out_old_prd[%0d]", i), out_old_prd[i*PW +: PW], m_old[i]);
      chk($sformatf("out_lrd[%0d]", i), out_lrd[i*LW +: LW], m_lrd[i]);
      chk($sformatf("out_payload[%0d]", i), out_payload[i*PLW +: PLW], m_pay[i]);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic run_group(input logic ordy, input logic fl);
    logic              e_ready, e_fire;
    logic [W-1:0]      ewen;
    logic [3*W*LW-1:0] eaddr;
    out_ready = ordy;
    flush_valid = fl;
    drive_ports();
    compute_model();
    #1;
    e_ready = ((m_valid == '0) || ordy) && (int'(s_cnt) >= e_need) && !fl;
    e_fire  = e_ready && s_valid[0];
    ewen    = e_fire ? e_wen : '0;
    chk("in_ready", in_ready, e_ready);
    chk("fl_alloc_cnt", fl_alloc_cnt, e_fire ? e_need : 0);
    chk("rat_wr_en", rat_wr_en, ewen);
    for (int i = 0; i < W; i++) begin
      eaddr[3*LW*i +: 3*LW] = {s_lrd[i], s_lrs2[i], s_lrs1[i]};
      if (ewen[i]) begin
        chk($sformatf("rat_wr_addr[%0d]", i), rat_wr_addr[i*LW +: LW], s_lrd[i]);
        chk($sformatf("rat_wr_data[%0d]", i), rat_wr_data[i*PW +: PW], e_prd[i]);
      end
    end
    chk("rat_rd_addr", rat_rd_addr, eaddr);
    @(posedge clock);
    if (fl)          m_valid = '0;
    else if (e_fire) m_valid = s_valid;
    else if (ordy)   m_valid = '0;
    if (e_fire) begin
      m_raw1 = e_raw1; m_raw2 = e_raw2; m_s1r = s_s1r; m_s2r = s_s2r; m_wb = s_wb;
      for (int i = 0; i < W; i++) begin
        m_prs1[i] = e_prs1[i]; m_prs2[i] = e_prs2[i]; m_prd[i] = e_prd[i];
        m_old[i] = e_old[i]; m_lrd[i] = s_lrd[i]; m_pay[i] = s_pay[i];
        if (e_wen[i]) rat[s_lrd[i]] = e_prd[i];
      end
    end
    @(negedge clock);
    check_outputs();
  endtask

  task automatic indep_group();
    clear_stim();
    s_valid = 4'hF; s_wb = 4'hF; s_s1r = 4'hF; s_s2r = 4'h5;
    for (int i = 0; i < W; i++) begin
      s_lrd[i] = LW'(i + 1); s_lrs1[i] = LW'(20 + i); s_lrs2[i] = LW'(24 + i);
    end
  endtask

  initial begin
    reset_n = 1'b0; out_ready = 1'b1; flush_valid = 1'b0;
    for (int r = 0; r < 32; r++) rat[r] = PW'(r);
    model_reset();
    clear_stim();
    drive_ports();
    repeat (2) @(negedge clock);
    chk("rst_out_valid", out_valid, '0);
    chk("rst_out_prd", out_prd, '0);
    chk("rst_out_payload0", out_payload[PLW-1:0], '0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_alloc", fl_alloc_cnt, '0);
    reset_n = 1'b1;
    @(negedge clock);

    // independent group
    indep_group();
    run_group(1'b1, 1'b0);
    chk("indep_prd", out_prd, {6'd13, 6'd12, 6'd11, 6'd10});
    chk("indep_valid", out_valid, 4'hF);

    // RAW chain
    clear_stim();
    s_valid = 4'b0111; s_wb = 4'b0111; s_s1r = 4'b0110; s_s2r = 4'b0100;
    s_lrd[0] = 5'd1;
    s_lrs1[1] = 5'd1; s_lrd[1] = 5'd2;
    s_lrs1[2] = 5'd2; s_lrs2[2] = 5'd1; s_lrd[2] = 5'd3;
    run_group(1'b1, 1'b0);
    chk("chain_s1_prs1", out_prs1[1*PW +: PW], 6'd10);
    chk("chain_s1_raw1", out_raw1[1], 1'b1);
    chk("chain_s2_prs1", out_prs1[2*PW +: PW], 6'd11);
    chk("chain_s2_prs2", out_prs2[2*PW +: PW], 6'd10);

    // WAW on r5
    clear_stim();
    s_valid = 4'b0111; s_wb = 4'b0111; s_s1r = 4'b0010;
    s_lrd[0] = 5'd5; s_lrs1[1] = 5'd5; s_lrd[1] = 5'd6; s_lrd[2] = 5'd5;
    run_group(1'b1, 1'b0);
    chk("waw_s1_prs1", out_prs1[1*PW +: PW], 6'd10);
    chk("waw_s2_old", out_old_prd[2*PW +: PW], 6'd10);
    chk("waw_s2_prd", out_prd[2*PW +: PW], 6'd12);

    // x0 destination and no-writeback slot
    clear_stim();
    s_valid = 4'hF; s_wb = 4'b0111; s_cnt = 3'd2;
    s_lrd[0] = 5'd7; s_lrd[1] = 5'd0; s_lrd[2] = 5'd8; s_lrd[3] = 5'd9;
    run_group(1'b1, 1'b0);
    chk("mixed_prd", out_prd, {6'd0, 6'd11, 6'd0, 6'd10});

    // short freelist, then enough
    clear_stim();
    s_valid = 4'b0111; s_wb = 4'b0111; s_cnt = 3'd1;
    s_lrd[0] = 5'd10; s_lrd[1] = 5'd11; s_lrd[2] = 5'd12;
    run_group(1'b1, 1'b0);
    chk("short_no_valid", out_valid, '0);
    s_cnt = 3'd3;
    run_group(1'b1, 1'b0);
    chk("short_fired", out_valid, 4'b0111);

    // stall for three cycles, then flush
    indep_group();
    run_group(1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      clear_stim();
      s_valid = 4'b0011; s_wb = 4'b0011; s_lrd[0] = 5'd14; s_lrd[1] = 5'd15;
      run_group(1'b0, 1'b0);
    end
    chk("stall_held", out_valid, 4'hF);
    run_group(1'b0, 1'b1);
    chk("flush_drop", out_valid, '0);

    // randomized groups
    for (int t = 0; t < 300; t++) begin
      int n;
      logic [PW-1:0] base;
      clear_stim();
      n = $urandom_range(0, W);
      s_valid = 4'((1 << n) - 1);
      s_wb  = 4'($urandom); s_s1r = 4'($urandom); s_s2r = 4'($urandom);
      s_cnt = CW'($urandom_range(0, W));
      base  = PW'($urandom_range(1, 59));
      for (int i = 0; i < W; i++) begin
        s_lrd[i]  = LW'($urandom_range(0, 7));
        s_lrs1[i] = LW'($urandom_range(0, 7));
        s_lrs2[i] = LW'($urandom_range(0, 7));
        s_fl[i]   = base + PW'(i);
      end
      run_group($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end

    // asynchronous reset with a group registered
    indep_group();
    run_group(1'b0, 1'b0);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_valid", out_valid, '0);
    chk("async_rst_prd", out_prd, '0);
    @(negedge clock);
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    indep_group();
    run_group(1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
